smpl_resp_checker: RTL
======================

// Module: smpl_resp_checker
// PURPOSE
//  Synthesizable response checker for smpl_circuit; the receiving end of the A/B/C -> x/y stimulus path.
//  Accepts each applied input vector over a valid/ready handshake, waits a settle time, samples x/y,
//  compares them against a parameterised truth table, and reports an error count and a pass/fail verdict.
//  Sits beside smpl_circuit in the on-chip self-test wrapper; a stimulus sequencer drives the vectors.
// PARAMETERS
//  EXP_X    8'h00  expected x per vector; bit index = {A,B,C}
//  EXP_Y    8'h00  expected y per vector; bit index = {A,B,C}
//  NUM_VEC  8      vectors per run, 1..255
//  SETTLE   2      cycles from vector accept to sample start, 0..15
// PORTS
//  clk          in   1  clock; all logic on the rising edge
//  rst          in   1  synchronous, active-high reset
//  start        in   1  begin a run; honoured only in IDLE or DONE
//  vec_valid    in   1  stimulus side is presenting vec_abc
//  vec_abc      in   3  applied vector {A,B,C}
//  vec_ready    out  1  checker accepts a vector this cycle
//  x, y         in   1  smpl_circuit outputs under test
//  busy         out  1  run in progress (WAIT_VEC, SETTLE or SAMPLE)
//  mismatch     out  1  one-cycle pulse in the cycle after a failing sample
//  err_cnt      out  4  failing vectors this run; saturates at 15
//  done         out  1  run complete; held until the next start or rst
//  pass         out  1  done && err_cnt==0; held with done
// BEHAVIOUR
//  - Reset: state=IDLE. vec_ready, busy, mismatch, done and pass are 0. err_cnt=0; vector count=0.
//  - FSM states: IDLE, WAIT_VEC, SETTLE, SAMPLE, DONE.
//  - IDLE: start -> WAIT_VEC; clear err_cnt and the vector count.
//  - WAIT_VEC: vec_ready=1. When vec_valid&&vec_ready, latch vec_abc into abc_q.
//    If SETTLE==0 go to SAMPLE; otherwise load the settle counter with SETTLE and go to SETTLE.
//  - SETTLE: decrement the counter each cycle; when the counter is 1, go to SAMPLE.
//  - SAMPLE: compare {x,y} against {EXP_X[abc_q],EXP_Y[abc_q]}.
//    On any difference: err_cnt += 1 (saturating) and mismatch=1 in the next cycle.
//    Increment the vector count. If the new count == NUM_VEC go to DONE, else go to WAIT_VEC.
//  - Latency: x/y are sampled SETTLE+1 cycles after the accept edge.
//    err_cnt, mismatch, done and pass are registered and update one cycle after the SAMPLE cycle.
//  - DONE: done=1 and pass holds its value. start -> WAIT_VEC in the next cycle.
//    The restart cycle clears err_cnt, the count, done and pass.
//  - vec_ready=0 outside WAIT_VEC. vec_valid is ignored then, and vec_abc is not latched.
//  - start during WAIT_VEC, SETTLE or SAMPLE is ignored; the run is not restarted.
//  - rst mid-run: next cycle is IDLE with all reset values; the partial run is discarded.
//  - err_cnt at 15 with a further mismatch: err_cnt stays 15; mismatch still pulses.
//  - The vector count is 8 bits and its terminal compare is against NUM_VEC.
//    It never wraps within a run.
// CONFIGURATION
//  SMPL_CHK_FIRST_FAIL_EN defined: adds outputs ff_vld(1), ff_abc(3) and ff_xy(2).
//    On the first mismatch of a run they capture abc_q and the observed {x,y}; later mismatches do not overwrite.
//    They are cleared by rst and by start; they are 0 until a failure is captured.
//  Undefined: those ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package smpl_chk_pkg: state encoding localparams (IDLE=0..DONE=4), ERR_W=4, ERR_MAX=15.
//  One sub-module: smpl_chk_settle_cnt (4-bit loadable down-counter with a done_o flag).
//  The FSM, compare and counters stay in the top level.
// TESTING
//  1. EXP_X=8'h96, EXP_Y=8'hE8, SETTLE=2, DUT correct; 8 vectors 0..7 -> done=1, pass=1, err_cnt=0, no mismatch pulse.
//  2. Same setup, y forced 0 for abc=3'b111 -> exactly 1 mismatch pulse, err_cnt=1, pass=0.
//  3. x inverted on all vectors, NUM_VEC=20 -> err_cnt saturates at 15; done=1, pass=0.
//  4. vec_valid held high during SETTLE with changing abc -> only WAIT_VEC vectors are latched;
//     sample occurs exactly SETTLE+1 cycles after accept; SETTLE=0 -> sample in the next cycle.
//  5. rst pulsed in SETTLE of vector 4 -> IDLE next cycle, outputs at reset values;
//     a fresh start gives a clean run with pass=1.
//  6. SMPL_CHK_FIRST_FAIL_EN defined, mismatches on abc=5 then abc=6 -> ff_vld=1, ff_abc=5,
//     ff_xy = observed at abc=5; start clears all three.

Source files
------------

// File: rtl/smpl_chk_pkg.sv
// +----------------------------------------------------------------------------+
// | smpl_chk_pkg : shared types and constants for the smpl_circuit checker      |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package smpl_chk_pkg;

  localparam logic [2:0] IDLE_ENC     = 3'd0;
  localparam logic [2:0] WAIT_VEC_ENC = 3'd1;
  localparam logic [2:0] SETTLE_ENC   = 3'd2;
  localparam logic [2:0] SAMPLE_ENC   = 3'd3;
  localparam logic [2:0] DONE_ENC     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = IDLE_ENC,
    ST_WAIT_VEC = WAIT_VEC_ENC,
    ST_SETTLE   = SETTLE_ENC,
    ST_SAMPLE   = SAMPLE_ENC,
    ST_DONE     = DONE_ENC
  } state_t;

  localparam int                 ERR_W    = 4;
  localparam logic [ERR_W-1:0]   ERR_MAX  = 4'd15;
  localparam int                 SETL_W   = 4;
  localparam int                 VCNT_W   = 8;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/smpl_chk_settle_cnt.sv
// +----------------------------------------------------------------------------+
// | smpl_chk_settle_cnt : loadable down-counter timing the x/y settle window    |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module smpl_chk_settle_cnt
  import smpl_chk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [SETL_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              done_o
);

  logic [SETL_W-1:0] cnt_q;
  logic [SETL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - SETL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last settle cycle is the one where the count reads 1.
  assign done_o = (cnt_q == SETL_W'(1));

endmodule

`default_nettype wire

// File: rtl/smpl_resp_checker.sv
// +----------------------------------------------------------------------------+
// | smpl_resp_checker : samples smpl_circuit x/y per vector, checks truth table |
// | Optional first-failure capture: SMPL_CHK_FIRST_FAIL_EN                      |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module smpl_resp_checker
  import smpl_chk_pkg::*;
#(
  parameter logic [7:0] EXP_X   = 8'h00,
  parameter logic [7:0] EXP_Y   = 8'h00,
  parameter int         NUM_VEC = 8,
  parameter int         SETTLE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             vec_valid_i,
  input  logic [2:0]       vec_abc_i,
  output logic             vec_ready_o,
  input  logic             x_i,
  input  logic             y_i,
  output logic             busy_o,
  output logic             mismatch_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             done_o,
`ifdef SMPL_CHK_FIRST_FAIL_EN
  output logic             ff_vld_o,
  output logic [2:0]       ff_abc_o,
  output logic [1:0]       ff_xy_o,
`endif
  output logic             pass_o
);

  localparam bit              SETTLE_ZERO = (SETTLE == 0);
  localparam logic [SETL_W-1:0] SETTLE_VAL = SETL_W'(SETTLE);
  localparam logic [VCNT_W-1:0] LAST_CNT   = VCNT_W'(NUM_VEC);

  state_t              state_q;
  logic [2:0]          abc_q;
  logic [VCNT_W-1:0]   vec_cnt_q;
  logic [ERR_W-1:0]    err_q;
  logic                mis_q;
  logic                done_q;
  logic                pass_q;
  logic                ready_q;
  logic                busy_q;

  logic                w_accept;
  logic                w_start_ok;
  logic [1:0]          w_exp_xy;
  logic                w_fail;
  logic [VCNT_W-1:0]   w_cnt_inc;
  logic                w_last;
  logic                w_settle_load;
  logic                w_settle_dec;
  logic                w_settle_done;

  assign w_accept      = ready_q && vec_valid_i;
  assign w_start_ok    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign w_exp_xy      = {EXP_X[abc_q], EXP_Y[abc_q]};
  assign w_fail        = ({x_i, y_i} != w_exp_xy);
  assign w_cnt_inc     = vec_cnt_q + VCNT_W'(1);
  assign w_last        = (w_cnt_inc == LAST_CNT);
  assign w_settle_load = w_accept && !SETTLE_ZERO;
  assign w_settle_dec  = (state_q == ST_SETTLE);

  smpl_chk_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_settle_load),
    .load_val_i (SETTLE_VAL),
    .dec_i      (w_settle_dec),
    .done_o     (w_settle_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      abc_q     <= '0;
      vec_cnt_q <= '0;
      err_q     <= '0;
      mis_q     <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q   <= ST_WAIT_VEC;
            vec_cnt_q <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_WAIT_VEC: begin
          if (w_accept) begin
            abc_q   <= vec_abc_i;
            ready_q <= 1'b0;
            state_q <= SETTLE_ZERO ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_settle_done) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_fail) begin
            err_q <= sat_inc(err_q);
            mis_q <= 1'b1;
          end
          vec_cnt_q <= w_cnt_inc;
          if (w_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !w_fail && (err_q == '0);
          end else begin
            state_q <= ST_WAIT_VEC;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign mismatch_o  = mis_q;
  assign err_cnt_o   = err_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;

`ifdef SMPL_CHK_FIRST_FAIL_EN
  logic       ff_vld_q;
  logic [2:0] ff_abc_q;
  logic [1:0] ff_xy_q;

  // Only the first failing vector of a run is kept; later ones are dropped.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      ff_vld_q <= 1'b0;
      ff_abc_q <= '0;
      ff_xy_q  <= '0;
    end else if ((state_q == ST_SAMPLE) && w_fail && !ff_vld_q) begin
      ff_vld_q <= 1'b1;
      ff_abc_q <= abc_q;
      ff_xy_q  <= {x_i, y_i};
    end
  end

  assign ff_vld_o = ff_vld_q;
  assign ff_abc_o = ff_abc_q;
  assign ff_xy_o  = ff_xy_q;
`else
  logic w_unused_start_ok;
  assign w_unused_start_ok = w_start_ok;
`endif

endmodule

`default_nettype wire
